// File: rtl/smg_scan_driver.sv
// Multiplexed seven-segment scan driver with shadowed inputs, hex decode,
// leading-zero blanking, per-digit decimal point and per-digit blink.
module smg_scan_driver #(
    parameter int DIGITS         = 6,
    parameter int SCAN_DIV       = 50000,
    parameter int BLINK_DIV      = 25000000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int SEL_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   number_data,
    input  logic [DIGITS-1:0]     dp_en,
    input  logic [DIGITS-1:0]     blink_en,
    input  logic                  blank_lz,
    input  logic                  hex_mode,
    output logic [7:0]            smg_data,
    output logic [DIGITS-1:0]     smg_sel,
    output logic                  frame_done
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_DIV);

    localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BCNT_MAX = BW'(BLINK_DIV - 1);

    localparam logic [7:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? '1 : '0;

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("smg_scan_driver: DIGITS must be 1..8");
    end
    if (SCAN_DIV < 2) begin : g_bad_scan
        $error("smg_scan_driver: SCAN_DIV must be >= 2");
    end
    if (BLINK_DIV < 2) begin : g_bad_blink
        $error("smg_scan_driver: BLINK_DIV must be >= 2");
    end
    if (SEG_ACTIVE_LOW != 0 && SEG_ACTIVE_LOW != 1) begin : g_bad_segpol
        $error("smg_scan_driver: SEG_ACTIVE_LOW must be 0 or 1");
    end
    if (SEL_ACTIVE_LOW != 0 && SEL_ACTIVE_LOW != 1) begin : g_bad_selpol
        $error("smg_scan_driver: SEL_ACTIVE_LOW must be 0 or 1");
    end

    // Active-low g..a pattern; hex letters are blank unless hex mode is on
    function automatic logic [6:0] seg_lut(input logic [3:0] n, input logic hx);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = hx ? 7'h08 : 7'h7F;
            4'hB:    s = hx ? 7'h03 : 7'h7F;
            4'hC:    s = hx ? 7'h46 : 7'h7F;
            4'hD:    s = hx ? 7'h21 : 7'h7F;
            4'hE:    s = hx ? 7'h06 : 7'h7F;
            default: s = hx ? 7'h0E : 7'h7F;
        endcase
        return s;
    endfunction

    logic [4*DIGITS-1:0] r_num;
    logic [DIGITS-1:0]   r_dp;
    logic [DIGITS-1:0]   r_blink;
    logic                r_blank_lz;
    logic                r_hex;
    logic [CW-1:0]       r_cnt;
    logic [IW-1:0]       r_idx;
    logic [BW-1:0]       r_bcnt;
    logic                r_phase;

    logic                w_adv;
    logic                w_wrap;
    logic [DIGITS-1:0]   w_zero;
    logic [3:0]          w_nib;
    logic [6:0]          w_seg;
    logic [7:0]          w_code;
    logic [DIGITS-1:0]   w_sel;

    assign w_adv  = (r_cnt == CNT_MAX);
    assign w_wrap = w_adv && (r_idx == IDX_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_num      <= '0;
            r_dp       <= '0;
            r_blink    <= '0;
            r_blank_lz <= 1'b0;
            r_hex      <= 1'b0;
        end else if (load) begin
            r_num      <= number_data;
            r_dp       <= dp_en;
            r_blink    <= blink_en;
            r_blank_lz <= blank_lz;
            r_hex      <= hex_mode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_adv) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else if (r_bcnt == BCNT_MAX) begin
            r_bcnt  <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_bcnt <= r_bcnt + 1'b1;
        end
    end

    // w_zero[i]: digit i and every digit above it hold zero
    always_comb begin
        logic v_run;
        v_run  = 1'b1;
        w_zero = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            v_run     = v_run & (r_num[4*i +: 4] == 4'd0);
            w_zero[i] = v_run;
        end
    end

    always_comb begin
        w_nib = r_num[{r_idx, 2'b00} +: 4];
        w_seg = seg_lut(w_nib, r_hex);
        if (r_blank_lz && (r_idx != '0) && w_zero[r_idx])
            w_seg = 7'h7F;
        w_code = {~r_dp[r_idx], w_seg};
        if (r_phase && r_blink[r_idx])
            w_code = 8'hFF;
        w_sel = DIGITS'(1) << r_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            smg_data   <= SEG_OFF;
            smg_sel    <= SEL_OFF;
            frame_done <= 1'b0;
        end else begin
            smg_data   <= (SEG_ACTIVE_LOW != 0) ? w_code : ~w_code;
            smg_sel    <= (SEL_ACTIVE_LOW != 0) ? ~w_sel : w_sel;
            frame_done <= w_wrap;
        end
    end

endmodule

// File: tb/tb_smg_scan_driver.sv
// Directed self-checking bench for smg_scan_driver (4 digits, fast dividers).
module tb_smg_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] number_data;
    logic [3:0]  dp_en;
    logic [3:0]  blink_en;
    logic        blank_lz;
    logic        hex_mode;
    logic [7:0]  smg_data;
    logic [3:0]  smg_sel;
    logic        frame_done;

    int n_checks = 0;
    int n_err    = 0;
    int j        = 0;

    smg_scan_driver #(
        .DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(32),
        .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .load(load),
        .number_data(number_data), .dp_en(dp_en), .blink_en(blink_en),
        .blank_lz(blank_lz), .hex_mode(hex_mode),
        .smg_data(smg_data), .smg_sel(smg_sel), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        j++;
    endtask

    task automatic tick_to(input int t);
        while (j < t) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reset, then release with a load on the same cycle; j counts edges
    // after release so j=1 is the first output update.
    task automatic start(input logic [15:0] num, input logic [3:0] dp,
                         input logic [3:0] bl, input logic lz, input logic hx);
        rst  = 1'b1;
        load = 1'b0;
        tick();
        tick();
        rst         = 1'b0;
        load        = 1'b1;
        number_data = num;
        dp_en       = dp;
        blink_en    = bl;
        blank_lz    = lz;
        hex_mode    = hx;
        j = 0;
        tick();
        load = 1'b0;
    endtask

    task automatic reload(input logic [15:0] num, input logic lz,
                          input logic hx);
        load        = 1'b1;
        number_data = num;
        blank_lz    = lz;
        hex_mode    = hx;
        tick();
        load = 1'b0;
    endtask

    initial begin
        logic [3:0] e_sel;
        logic [7:0] e_dat;
        int         idx;

        rst = 1'b1; load = 1'b0; number_data = '0; dp_en = '0;
        blink_en = '0; blank_lz = 1'b0; hex_mode = 1'b0;
        tick(); tick(); tick();
        chk("reset_data", 32'(smg_data), 32'hFF);
        chk("reset_sel", 32'(smg_sel), 32'hF);
        chk("reset_fd", 32'(frame_done), 32'h0);

        // Scan order and frame pulse
        start(16'h1234, 4'h0, 4'h0, 1'b0, 1'b0);
        chk("scan_first_sel", 32'(smg_sel), 32'hE);
        chk("scan_first_data", 32'(smg_data), 32'hC0);
        chk("scan_first_fd", 32'(frame_done), 32'h0);
        for (int t = 2; t <= 48; t++) begin
            tick();
            idx = ((j - 1) / 4) % 4;
            e_sel = ~(4'b0001 << idx);
            case (idx)
                0:       e_dat = 8'h99;
                1:       e_dat = 8'hB0;
                2:       e_dat = 8'hA4;
                default: e_dat = 8'hF9;
            endcase
            chk($sformatf("scan_sel_j%0d", j), 32'(smg_sel), 32'(e_sel));
            chk($sformatf("scan_data_j%0d", j), 32'(smg_data), 32'(e_dat));
            chk($sformatf("scan_fd_j%0d", j), 32'(frame_done),
                32'((j % 16) == 0));
        end

        // Hex letters: blank without hex mode, letter with it
        start(16'h000A, 4'h0, 4'h0, 1'b0, 1'b0);
        tick_to(2);
        chk("hex_off_d0", 32'(smg_data), 32'hFF);
        tick_to(5);
        reload(16'h000A, 1'b0, 1'b1);
        tick_to(6);
        chk("hex_d1_zero", 32'(smg_data), 32'hC0);
        tick_to(18);
        chk("hex_on_sel", 32'(smg_sel), 32'hE);
        chk("hex_on_d0", 32'(smg_data), 32'h88);

        // Leading-zero blanking
        start(16'h0050, 4'h0, 4'h0, 1'b1, 1'b0);
        tick_to(2);  chk("lz50_d0", 32'(smg_data), 32'hC0);
        tick_to(6);  chk("lz50_d1", 32'(smg_data), 32'h92);
        tick_to(10); chk("lz50_d2", 32'(smg_data), 32'hFF);
        tick_to(14); chk("lz50_d3", 32'(smg_data), 32'hFF);
        tick_to(15);
        reload(16'h0000, 1'b1, 1'b0);
        tick_to(18); chk("lz00_d0", 32'(smg_data), 32'hC0);
        tick_to(22); chk("lz00_d1", 32'(smg_data), 32'hFF);
        tick_to(26); chk("lz00_d2", 32'(smg_data), 32'hFF);
        tick_to(30); chk("lz00_d3", 32'(smg_data), 32'hFF);

        // Decimal point and blink phase
        start(16'h1234, 4'b0010, 4'b0001, 1'b0, 1'b0);
        tick_to(2);  chk("blk_d0_ph0a", 32'(smg_data), 32'h99);
        tick_to(6);  chk("dp_d1", 32'(smg_data), 32'h30);
        tick_to(18); chk("blk_d0_ph0b", 32'(smg_data), 32'h99);
        tick_to(34); chk("blk_d0_ph1a", 32'(smg_data), 32'hFF);
        chk("blk_sel_ph1", 32'(smg_sel), 32'hE);
        tick_to(38); chk("dp_d1_ph1", 32'(smg_data), 32'h30);
        tick_to(50); chk("blk_d0_ph1b", 32'(smg_data), 32'hFF);
        tick_to(66); chk("blk_d0_ph0c", 32'(smg_data), 32'h99);

        // Mid-frame reset
        start(16'h1234, 4'h0, 4'h0, 1'b0, 1'b0);
        tick_to(10);
        chk("mid_pre_sel", 32'(smg_sel), 32'hB);
        rst = 1'b1;
        tick();
        chk("mid_rst_data", 32'(smg_data), 32'hFF);
        chk("mid_rst_sel", 32'(smg_sel), 32'hF);
        chk("mid_rst_fd", 32'(frame_done), 32'h0);
        rst = 1'b0;
        j = 0;
        for (int t = 1; t <= 4; t++) begin
            tick();
            chk($sformatf("mid_post_sel_j%0d", j), 32'(smg_sel), 32'hE);
            chk($sformatf("mid_post_data_j%0d", j), 32'(smg_data), 32'hC0);
        end
        tick();
        chk("mid_post_sel_next", 32'(smg_sel), 32'hD);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
